// File: rtl/pipe_mem_arbiter_if.sv
// Bus bundle between the pipeline/RAM side and pipe_mem_arbiter.
// master: pipeline requesters plus the RAM read-data return.
// slave:  the arbiter itself.
interface pipe_mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready, stall,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
        output if_rdata, if_ready, mem_rdata, mem_ready, stall,
               ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/pipe_mem_arbiter.sv
// Arbiter sharing one single-ported instruction/data RAM between the IF-stage
// fetch and the MEM-stage load/store. MEM has fixed priority. Each access
// spends WAIT_CYCLES+1 cycles in an ACC state and one cycle in RESP; the
// requester's done flag is held until the pipeline advances (stall low).
// Optional macro ARB_PERF_CNT_EN adds stall_cycles / conflict_cnt counters.
module pipe_mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned CNT_W       = 3
) (
    input  logic              clk,
    input  logic              clrn,
    pipe_mem_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       conflict_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, IF_ACC, MEM_ACC, RESP} state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic               if_done;
    logic               mem_done;
    logic               served_mem;
    logic               if_elig;
    logic               mem_elig;
    logic               acc_last;
    logic               grant_mem;
    logic               grant_if;
    logic               acc_done;

    assign mem_elig     = bus.mem_req & ~mem_done;
    assign if_elig      = bus.if_req & ~if_done;
    assign bus.stall    = mem_elig | if_elig;
    assign bus.if_ready = if_done;
    assign bus.mem_ready = mem_done;
    assign acc_last     = (cnt == CNT_W'(WAIT_CYCLES));

    // Next-state decode and per-edge action strobes.
    always_comb begin
        state_next = state;
        grant_mem  = 1'b0;
        grant_if   = 1'b0;
        acc_done   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_elig) begin
                    grant_mem  = 1'b1;
                    state_next = MEM_ACC;
                end else if (if_elig) begin
                    grant_if   = 1'b1;
                    state_next = IF_ACC;
                end
            end
            IF_ACC, MEM_ACC: begin
                if (acc_last) begin
                    acc_done   = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) state <= IDLE;
        else      state <= state_next;
    end

    // RAM request registers, wait-state counter and read-data capture.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            cnt           <= '0;
            served_mem    <= 1'b0;
            bus.ram_en    <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.if_rdata  <= '0;
            bus.mem_rdata <= '0;
        end else if (grant_mem) begin
            bus.ram_addr  <= bus.mem_addr;
            bus.ram_wdata <= bus.mem_wdata;
            bus.ram_we    <= bus.mem_we;
            bus.ram_en    <= 1'b1;
            cnt           <= '0;
            served_mem    <= 1'b1;
        end else if (grant_if) begin
            bus.ram_addr  <= bus.if_addr;
            bus.ram_we    <= 1'b0;
            bus.ram_en    <= 1'b1;
            cnt           <= '0;
            served_mem    <= 1'b0;
        end else if (acc_done) begin
            bus.ram_en <= 1'b0;
            bus.ram_we <= 1'b0;
            if (state == MEM_ACC) begin
                if (!bus.ram_we) bus.mem_rdata <= bus.ram_rdata;
            end else begin
                bus.if_rdata <= bus.ram_rdata;
            end
        end else if (state == IF_ACC || state == MEM_ACC) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Done flags: posted as RESP retires so stall stays high through RESP;
    // posting wins over the stall-low clear for a request dropped mid-access.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
        end else begin
            if (!bus.stall) begin
                if_done  <= 1'b0;
                mem_done <= 1'b0;
            end
            if (state == RESP) begin
                if (served_mem) mem_done <= 1'b1;
                else            if_done  <= 1'b1;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    // Performance counters: stalled edges and two-way contention at grant.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            stall_cycles <= '0;
            conflict_cnt <= '0;
        end else begin
            if (bus.stall) stall_cycles <= stall_cycles + 32'd1;
            if (state == IDLE && mem_elig && if_elig) conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Self-checking bench for pipe_mem_arbiter: a transaction-timeline model
// checked every cycle on DUT0 (WAIT_CYCLES=1), plus directed literal checks,
// and a back-to-back fetch run on DUT1 (WAIT_CYCLES=0).
module tb_pipe_mem_arbiter;
    localparam int unsigned W0 = 1;
    localparam int unsigned W1 = 0;

    logic clk = 1'b0;
    logic clrn;
    logic ram_load;
    always #5 clk = ~clk;

    pipe_mem_arbiter_if bus0();
    pipe_mem_arbiter_if bus1();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] stall_cycles0, conflict_cnt0, stall_cycles1, conflict_cnt1;
`endif

    pipe_mem_arbiter #(.WAIT_CYCLES(W0), .CNT_W(3)) u_dut0 (
        .clk(clk), .clrn(clrn), .bus(bus0)
`ifdef ARB_PERF_CNT_EN
        , .stall_cycles(stall_cycles0), .conflict_cnt(conflict_cnt0)
`endif
    );

    pipe_mem_arbiter #(.WAIT_CYCLES(W1), .CNT_W(3)) u_dut1 (
        .clk(clk), .clrn(clrn), .bus(bus1)
`ifdef ARB_PERF_CNT_EN
        , .stall_cycles(stall_cycles1), .conflict_cnt(conflict_cnt1)
`endif
    );

    function automatic logic [31:0] init_word(input int unsigned i);
        if (i == 16)       return 32'h8C01_0004;
        else if (i == 128) return 32'h1234_5678;
        else               return 32'h5A00_0000 + i;
    endfunction

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    bit          chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Wait-state RAM models: data is valid only in the last enabled cycle.
    logic [31:0] ram0 [256];
    logic [31:0] ram1 [256];
    int unsigned en_cnt0 = 0, en_cnt1 = 0, acc0 = 0, acc1 = 0;

    assign bus0.ram_rdata = (bus0.ram_en && en_cnt0 == W0) ? ram0[bus0.ram_addr[9:2]]
                                                           : {24'hBAD000, bus0.ram_addr[7:0]};
    assign bus1.ram_rdata = (bus1.ram_en && en_cnt1 == W1) ? ram1[bus1.ram_addr[9:2]]
                                                           : {24'hBAD000, bus1.ram_addr[7:0]};

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) begin
                ram0[i] <= init_word(i);
                ram1[i] <= init_word(i);
            end
        end
        if (!bus0.ram_en) en_cnt0 <= 0;
        else begin
            en_cnt0 <= en_cnt0 + 1;
            if (en_cnt0 == W0) begin
                acc0 <= acc0 + 1;
                if (bus0.ram_we) ram0[bus0.ram_addr[9:2]] <= bus0.ram_wdata;
            end
        end
        if (!bus1.ram_en) en_cnt1 <= 0;
        else begin
            en_cnt1 <= en_cnt1 + 1;
            if (en_cnt1 == W1) begin
                acc1 <= acc1 + 1;
                if (bus1.ram_we) ram1[bus1.ram_addr[9:2]] <= bus1.ram_wdata;
            end
        end
    end

    // Timeline model of DUT0: an access granted at edge k=0 holds the RAM for
    // k=0..W, captures at k=W+1 and reports done at k=W+2.
    bit          m_busy, m_who_mem, m_we, m_id, m_md;
    int unsigned m_k;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_mem_rdata;
    logic [31:0] m_mem [256];
    int unsigned m_stall_edges, m_conflicts;

    task automatic model_reset();
        m_busy = 0; m_who_mem = 0; m_we = 0; m_id = 0; m_md = 0; m_k = 0;
        m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_mem_rdata = '0;
        m_stall_edges = 0; m_conflicts = 0;
    endtask

    task automatic model_edge();
        bit me, ie, st;
        me = bus0.mem_req && !m_md;
        ie = bus0.if_req && !m_id;
        st = me || ie;
        if (st) m_stall_edges++;
        else begin m_id = 0; m_md = 0; end
        if (!m_busy) begin
            if (me && ie) m_conflicts++;
            if (me) begin
                m_busy = 1; m_who_mem = 1; m_k = 0;
                m_addr = bus0.mem_addr; m_we = bus0.mem_we; m_wdata = bus0.mem_wdata;
            end else if (ie) begin
                m_busy = 1; m_who_mem = 0; m_k = 0; m_addr = bus0.if_addr; m_we = 0;
            end
        end else begin
            m_k++;
            if (m_k == W0 + 1) begin
                if (m_who_mem && m_we) m_mem[m_addr[9:2]] = m_wdata;
                else if (m_who_mem)    m_mem_rdata = m_mem[m_addr[9:2]];
                else                   m_if_rdata  = m_mem[m_addr[9:2]];
            end else if (m_k == W0 + 2) begin
                m_busy = 0;
                if (m_who_mem) m_md = 1; else m_id = 1;
            end
        end
    endtask

    // Per-cycle comparison of DUT0 against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("stall", 32'(bus0.stall), 32'((bus0.mem_req && !m_md) || (bus0.if_req && !m_id)));
            chk("if_ready", 32'(bus0.if_ready), 32'(m_id));
            chk("mem_ready", 32'(bus0.mem_ready), 32'(m_md));
            chk("if_rdata", bus0.if_rdata, m_if_rdata);
            chk("mem_rdata", bus0.mem_rdata, m_mem_rdata);
            chk("ram_en", 32'(bus0.ram_en), 32'(m_busy && m_k <= W0));
            chk("ram_we", 32'(bus0.ram_we), 32'(m_busy && m_k <= W0 && m_we));
            chk("ram_addr", bus0.ram_addr, m_addr);
            chk("ram_wdata", bus0.ram_wdata, m_wdata);
`ifdef ARB_PERF_CNT_EN
            chk("stall_cycles", stall_cycles0, m_stall_edges);
            chk("conflict_cnt", conflict_cnt0, m_conflicts);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        if (!clrn) model_edge();
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ram_en"}, 32'(bus0.ram_en), 32'd0);
        chk({tag, "_ram_we"}, 32'(bus0.ram_we), 32'd0);
        chk({tag, "_ram_addr"}, bus0.ram_addr, 32'd0);
        chk({tag, "_ram_wdata"}, bus0.ram_wdata, 32'd0);
        chk({tag, "_if_rdata"}, bus0.if_rdata, 32'd0);
        chk({tag, "_mem_rdata"}, bus0.mem_rdata, 32'd0);
        chk({tag, "_ready"}, 32'({bus0.if_ready, bus0.mem_ready}), 32'd0);
    endtask

    // Asynchronous pulse landing between clock edges.
    task automatic pulse_reset();
        clrn = 1'b1;
        model_reset();
        #1;
        check_zero("midrst");
        #1;
        clrn = 1'b0;
    endtask

    int          rdy_if, rdy_mem, we_cycles;
    logic [15:0] spat;
    logic [31:0] got_if, got_mem, we_addr, we_wdata;
    logic [31:0] rises [$];

    task automatic serve(input bit need_if, input bit need_mem);
        bit prev_en;
        rdy_if = -1; rdy_mem = -1; spat = '0; we_cycles = 0;
        got_if = '0; got_mem = '0; we_addr = '0; we_wdata = '0;
        rises.delete();
        prev_en = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            spat[c] = bus0.stall;
            if (bus0.ram_en && !prev_en) rises.push_back(bus0.ram_addr);
            prev_en = bus0.ram_en;
            if (bus0.ram_we) begin
                we_cycles++; we_addr = bus0.ram_addr; we_wdata = bus0.ram_wdata;
            end
            if (bus0.if_ready && rdy_if < 0) begin rdy_if = c; got_if = bus0.if_rdata; end
            if (bus0.mem_ready && rdy_mem < 0) begin rdy_mem = c; got_mem = bus0.mem_rdata; end
            cyc();
            if ((!need_if || rdy_if >= 0) && (!need_mem || rdy_mem >= 0)) break;
        end
        bus0.if_req = 1'b0; bus0.mem_req = 1'b0; bus0.mem_we = 1'b0;
    endtask

    initial begin
        int unsigned acc_base;
        int          rdy;
        logic [31:0] got;

        clrn = 1'b1; ram_load = 1'b1;
        bus0.if_req = 0; bus0.if_addr = '0; bus0.mem_req = 0; bus0.mem_we = 0;
        bus0.mem_addr = '0; bus0.mem_wdata = '0;
        bus1.if_req = 0; bus1.if_addr = '0; bus1.mem_req = 0; bus1.mem_we = 0;
        bus1.mem_addr = '0; bus1.mem_wdata = '0;
        for (int i = 0; i < 256; i++) m_mem[i] = init_word(i);
        model_reset();
        cyc(); cyc();
        ram_load = 1'b0;
        check_zero("rst");
        chk("rst_stall", 32'(bus0.stall), 32'd0);
        clrn = 1'b0; chk_on = 1'b1;
        cyc();

        // Single fetch, WAIT_CYCLES=1.
        bus0.if_addr = 32'h0000_0040; bus0.if_req = 1'b1;
        serve(1'b1, 1'b0);
        chk("fetch_latency", 32'(rdy_if), 32'd4);
        chk("fetch_data", got_if, 32'h8C01_0004);
        chk("fetch_stall_pattern", 32'(spat), 32'h0000_000F);

        // Store.
        bus0.mem_addr = 32'h100; bus0.mem_wdata = 32'hDEAD_BEEF;
        bus0.mem_we = 1'b1; bus0.mem_req = 1'b1;
        serve(1'b0, 1'b1);
        chk("store_latency", 32'(rdy_mem), 32'd4);
        chk("store_we_cycles", 32'(we_cycles), 32'd2);
        chk("store_addr", we_addr, 32'h100);
        chk("store_wdata", we_wdata, 32'hDEAD_BEEF);
        chk("store_mem_rdata", bus0.mem_rdata, 32'd0);
        chk("store_ram_word", ram0[64], 32'hDEAD_BEEF);

        // Simultaneous fetch and load.
        acc_base = acc0;
        bus0.if_addr = 32'h40; bus0.if_req = 1'b1;
        bus0.mem_addr = 32'h200; bus0.mem_we = 1'b0; bus0.mem_req = 1'b1;
        serve(1'b1, 1'b1);
        chk("both_mem_latency", 32'(rdy_mem), 32'd4);
        chk("both_if_latency", 32'(rdy_if), 32'd8);
        chk("both_stall_pattern", 32'(spat), 32'h0000_00FF);
        chk("both_grants", 32'(rises.size()), 32'd2);
        chk("both_first_grant", (rises.size() > 0) ? rises[0] : 32'hFFFF_FFFF, 32'h200);
        chk("both_second_grant", (rises.size() > 1) ? rises[1] : 32'hFFFF_FFFF, 32'h40);
        chk("both_ram_accesses", 32'(acc0 - acc_base), 32'd2);
        chk("both_if_data", got_if, 32'h8C01_0004);
        chk("both_mem_data", got_mem, 32'h1234_5678);
`ifdef ARB_PERF_CNT_EN
        chk("perf_conflicts", conflict_cnt0, 32'd1);
        chk("perf_stall_edges", stall_cycles0, 32'd16);
`endif

        // Reset during MEM_ACC, then a normal fetch.
        bus0.mem_addr = 32'h200; bus0.mem_we = 1'b0; bus0.mem_req = 1'b1;
        cyc(); cyc();
        bus0.mem_req = 1'b0;
        pulse_reset();
        bus0.if_addr = 32'h44; bus0.if_req = 1'b1;
        serve(1'b1, 1'b0);
        chk("post_rst_latency", 32'(rdy_if), 32'd4);
        chk("post_rst_data", got_if, 32'h5A00_0011);

        // Back-to-back fetches on the zero-wait-state instance.
        acc_base = acc1;
        bus1.if_req = 1'b1;
        for (int j = 0; j < 3; j++) begin
            bus1.if_addr = 32'(j * 4);
            rdy = -1; got = '0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (bus1.if_ready) begin rdy = c; got = bus1.if_rdata; end
                cyc();
                if (rdy >= 0) break;
            end
            chk("b2b_latency", 32'(rdy), 32'd3);
            chk("b2b_data", got, 32'h5A00_0000 + 32'(j));
        end
        bus1.if_req = 1'b0;
        cyc(); cyc(); cyc();
        chk("b2b_ram_accesses", 32'(acc1 - acc_base), 32'd3);
`ifdef ARB_PERF_CNT_EN
        chk("b2b_conflicts", conflict_cnt1, 32'd0);
        chk("b2b_stall_edges", stall_cycles1, 32'd9);
`endif

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
